// File: rtl/hadd_serial_ctrl.sv
// Bit-serial adder: one shared half-adder pair plus a registered carry adds two
// WIDTH-bit operands one bit per clock. Optional carry-in port: HADD_SERIAL_CIN_EN.

module hadd (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module hadd_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef HADD_SERIAL_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_cin;

`ifdef HADD_SERIAL_CIN_EN
  assign w_cin = cin;
`else
  assign w_cin = 1'b0;
`endif

  // Two half adders chained into a full adder; the OR of their carries feeds r_carry.
  hadd u_hadd0 (.i_a(r_opa[0]), .i_b(r_opb[0]), .o_s(w_s1), .o_c(w_c1));
  hadd u_hadd1 (.i_a(w_s1),     .i_b(r_carry),  .o_s(w_s),  .o_c(w_c2));

  assign w_carry_next = w_c1 | w_c2;
  assign w_acc_next   = {w_s, r_acc[WIDTH-1:1]};
  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= b;
            r_cnt   <= '0;
            r_carry <= w_cin;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_acc   <= w_acc_next;
          r_carry <= w_carry_next;
          r_cnt   <= r_cnt + 1'b1;
          // The last bit is folded in on the same edge that publishes the result.
          if (w_last) begin
            r_state <= S_DONE;
            r_sum   <= w_acc_next;
            r_cout  <= w_carry_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_hadd_serial_ctrl.sv
// Scoreboard bench for hadd_serial_ctrl: the driver predicts acceptance and
// queues a+b(+cin); a monitor checks busy/done timing and results every cycle.

module tb_hadd_serial_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  hadd_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
`ifdef HADD_SERIAL_CIN_EN
    .cin(cin),
`endif
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_edges = 0;
  int n_accepted = 0;

  // Reference model: an operation accepted at edge E is busy after edges
  // E..E+WIDTH-1 and presents done after edge E+WIDTH.
  bit              op_valid = 1'b0;
  int              last_e = 0;
  int              next_ok = 0;
  logic [WIDTH:0]  exp_q[$];
  logic [WIDTH:0]  held = '0;

  task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, n_edges, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    n_edges = n_edges + 1;
  end

  // Monitor
  initial forever begin
    logic exp_busy;
    logic exp_done;
    @(posedge clk);
    #1;
    exp_busy = op_valid && (last_e <= n_edges) && (n_edges < last_e + WIDTH);
    exp_done = op_valid && (n_edges == last_e + WIDTH);
    check("busy", {{WIDTH{1'b0}}, busy}, {{WIDTH{1'b0}}, exp_busy});
    check("done", {{WIDTH{1'b0}}, done}, {{WIDTH{1'b0}}, exp_done});
    if (done === 1'b1) begin
      check("scoreboard_nonempty", {{WIDTH{1'b0}}, exp_q.size() > 0}, {{WIDTH{1'b0}}, 1'b1});
      if (exp_q.size() > 0) held = exp_q.pop_front();
    end
    check("result", {cout, sum}, held);
  end

  // Called right after a falling edge; the next rising edge is n_edges+1.
  task automatic drive(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv);
    logic c_eff;
`ifdef HADD_SERIAL_CIN_EN
    c_eff = cv;
`else
    c_eff = 1'b0;
`endif
    start = s;
    a     = av;
    b     = bv;
    cin   = cv;
    if (s && rst_n && (n_edges >= next_ok)) begin
      op_valid = 1'b1;
      last_e   = n_edges + 1;
      next_ok  = n_edges + 1 + WIDTH;
      exp_q.push_back({1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, c_eff});
      n_accepted++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      drive(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
  endtask

  task automatic apply_reset(input int k);
    rst_n    = 1'b0;
    start    = 1'b0;
    op_valid = 1'b0;
    next_ok  = 0;
    held     = '0;
    exp_q.delete();
    repeat (k) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, edges=%0d", n_edges);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    apply_reset(3);

    drive(1'b1, 8'h0F, 8'h01, 1'b0);
    idle(11);

    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    idle(11);
    drive(1'b1, 8'hFF, 8'h00, 1'b1);
    idle(11);

    // start held high; new operands appear during the done cycle
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    repeat (8) drive(1'b1, 8'h12, 8'h34, 1'b0);
    drive(1'b1, 8'hA0, 8'h60, 1'b0);
    idle(12);

    // start with new operands in the middle of RUN is ignored
    drive(1'b1, 8'h5A, 8'h3C, 1'b0);
    idle(2);
    drive(1'b1, 8'hC3, 8'h77, 1'b1);
    idle(11);

    // reset mid-operation, then a normal operation
    drive(1'b1, 8'h81, 8'h92, 1'b0);
    idle(3);
    apply_reset(2);
    idle(3);
    drive(1'b1, 8'h33, 8'h44, 1'b0);
    idle(11);

    drive(1'b1, 8'h00, 8'h00, 1'b0);
    idle(11);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    idle(11);

    n_accepted = 0;
    while (n_accepted < 1000)
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    idle(12);

    check("scoreboard_drained", WIDTH'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
